// File: rtl/fp_mac_pkg.sv
// Shared constants for the FP MAC adder path: field widths, saturation
// exponent and bit positions inside the raw align/add sum.
package fp_mac_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int RAW_W  = 28;

  // Raw sum minus the carry bit: {hidden, fraction, G, R, S}
  localparam int NORM_W = RAW_W - 1;
  localparam int LZ_W   = 5;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  localparam int CARRY_BIT  = RAW_W - 1;
  localparam int HIDDEN_BIT = RAW_W - 2;
  localparam int G_BIT      = 2;
  localparam int R_BIT      = 1;
  localparam int S_BIT      = 0;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over the 27-bit {hidden, fraction, G, R, S} field.
// The count is taken relative to the top bit; an all-zero input gives 27.
module fp_lzc
  import fp_mac_pkg::*;
(
  input  logic [NORM_W-1:0] din,
  output logic [LZ_W-1:0]   count
);

  // Scan upward so the highest set bit is the last one to write the count
  always_comb begin
    count = LZ_W'(NORM_W);
    for (int i = 0; i < NORM_W; i++) begin
      if (din[i]) begin
        count = LZ_W'(NORM_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_adder_normalize_round.sv
// Normalize and round-to-nearest-even stage of the FP MAC adder path.
// Stage 1 normalizes the raw sum (carry shift or leading-zero shift),
// stage 2 rounds and resolves overflow/underflow. Subnormals flush to zero.
module fp_adder_normalize_round #(
  parameter int EXP_W  = fp_mac_pkg::EXP_W,
  parameter int FRAC_W = fp_mac_pkg::FRAC_W,
  parameter int RAW_W  = fp_mac_pkg::RAW_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exponent,
  input  logic [RAW_W-1:0]  in_raw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [EXP_W-1:0]  exponent,
  output logic [FRAC_W:0]   significand,
  output logic              overflow,
  output logic              underflow
);

  import fp_mac_pkg::*;

  localparam int SIG_W = FRAC_W + 1;
  localparam int XE_W  = EXP_W + 2;

  // Exponents are widened and signed so e-lz and e+1 never wrap
  localparam logic signed [XE_W-1:0] ONE_S     = XE_W'(1);
  localparam logic signed [XE_W-1:0] ZERO_S    = '0;
  localparam logic signed [XE_W-1:0] EXP_MAX_S = $signed({2'b00, {EXP_W{1'b1}}});

  // Round-to-nearest-even on {significand, G, R, S}; MSB of result is the carry out
  function automatic logic [SIG_W:0] round_rne(input logic [NORM_W-1:0] n);
    logic [SIG_W-1:0] sig;
    logic             up;
    sig = n[NORM_W-1:G_BIT+1];
    up  = n[G_BIT] & (n[R_BIT] | n[S_BIT] | sig[0]);
    return {1'b0, sig} + (SIG_W+1)'(up);
  endfunction

  // An exponent at or above the all-ones code saturates to infinity
  function automatic logic exp_saturates(input logic signed [XE_W-1:0] e);
    return e >= EXP_MAX_S;
  endfunction

  logic              advance;
  logic [LZ_W-1:0]   lz;

  logic [NORM_W-1:0] norm_c;
  logic [EXP_W-1:0]  exp_c;
  logic              ovf_c;
  logic              unf_c;
  logic signed [XE_W-1:0] exp_inc_c;
  logic signed [XE_W-1:0] exp_sub_c;

  logic              vld_p1;
  logic              sign_p1;
  logic [EXP_W-1:0]  exp_p1;
  logic [NORM_W-1:0] norm_p1;
  logic              ovf_p1;
  logic              unf_p1;

  logic [SIG_W:0]    rounded_c;
  logic signed [XE_W-1:0] exp_rnd_c;
  logic [SIG_W-1:0]  sig2_c;
  logic [EXP_W-1:0]  exp2_c;
  logic              ovf2_c;

  logic              vld_p2;
  logic              sign_p2;
  logic [EXP_W-1:0]  exp_p2;
  logic [SIG_W-1:0]  sig_p2;
  logic              ovf_p2;
  logic              unf_p2;

  // Both stages move together whenever the output slot is free or draining
  assign advance  = !vld_p2 || out_ready;
  assign in_ready = advance;

  fp_lzc u_lzc (
    .din   (in_raw[HIDDEN_BIT:0]),
    .count (lz)
  );

  // ---- Stage 1: normalize ----
  // Pick carry shift, leading-zero shift or exact zero and flag range errors
  always_comb begin
    norm_c    = '0;
    exp_c     = '0;
    ovf_c     = 1'b0;
    unf_c     = 1'b0;
    exp_inc_c = $signed({2'b00, in_exponent}) + ONE_S;
    exp_sub_c = $signed({2'b00, in_exponent}) - $signed({{(XE_W-LZ_W){1'b0}}, lz});
    if (in_raw == '0) begin
      norm_c = '0;
    end else if (in_raw[CARRY_BIT]) begin
      if (exp_saturates(exp_inc_c)) begin
        ovf_c = 1'b1;
      end else begin
        // The bit shifted out of R folds into sticky
        norm_c = {in_raw[CARRY_BIT:G_BIT], in_raw[R_BIT] | in_raw[S_BIT]};
        exp_c  = exp_inc_c[EXP_W-1:0];
      end
    end else begin
      if (exp_sub_c <= ZERO_S) begin
        unf_c = 1'b1;
      end else begin
        norm_c = in_raw[HIDDEN_BIT:0] << lz;
        exp_c  = exp_sub_c[EXP_W-1:0];
      end
    end
  end

  // Stage 1 register; holds while the output is stalled
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_p1  <= 1'b0;
      sign_p1 <= 1'b0;
      exp_p1  <= '0;
      norm_p1 <= '0;
      ovf_p1  <= 1'b0;
      unf_p1  <= 1'b0;
    end else if (advance) begin
      vld_p1  <= in_valid;
      sign_p1 <= in_sign;
      exp_p1  <= exp_c;
      norm_p1 <= norm_c;
      ovf_p1  <= ovf_c;
      unf_p1  <= unf_c;
    end
  end

  // ---- Stage 2: round ----
  // Round, absorb the rounding carry, then apply infinity/zero substitution
  always_comb begin
    rounded_c = round_rne(norm_p1);
    exp_rnd_c = $signed({2'b00, exp_p1}) + ONE_S;
    sig2_c    = rounded_c[SIG_W-1:0];
    exp2_c    = exp_p1;
    ovf2_c    = ovf_p1;
    if (rounded_c[SIG_W]) begin
      sig2_c = {1'b1, {FRAC_W{1'b0}}};
      if (exp_saturates(exp_rnd_c)) begin
        ovf2_c = 1'b1;
      end else begin
        exp2_c = exp_rnd_c[EXP_W-1:0];
      end
    end
    if (ovf2_c) begin
      exp2_c = EXP_MAX;
      sig2_c = '0;
    end
    if (unf_p1) begin
      exp2_c = '0;
      sig2_c = '0;
    end
  end

  // Output register; results hold while out_valid && !out_ready
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_p2  <= 1'b0;
      sign_p2 <= 1'b0;
      exp_p2  <= '0;
      sig_p2  <= '0;
      ovf_p2  <= 1'b0;
      unf_p2  <= 1'b0;
    end else if (advance) begin
      vld_p2  <= vld_p1;
      sign_p2 <= sign_p1;
      exp_p2  <= exp2_c;
      sig_p2  <= sig2_c;
      ovf_p2  <= ovf2_c;
      unf_p2  <= unf_p1;
    end
  end

  assign out_valid   = vld_p2;
  assign sign        = sign_p2;
  assign exponent    = exp_p2;
  assign significand = sig_p2;
  assign overflow    = ovf_p2;
  assign underflow   = unf_p2;

endmodule

// File: tb/tb_fp_adder_normalize_round.sv
// Bench for fp_adder_normalize_round: directed cases plus randomized traffic
// with random backpressure, checked against an arithmetic reference model.
module tb_fp_adder_normalize_round;

  typedef struct packed {
    logic        sign;
    logic [7:0]  ex;
    logic [23:0] sig;
    logic        ovf;
    logic        unf;
  } res_t;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [27:0] in_raw;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [7:0]  exponent;
  logic [23:0] significand;
  logic        overflow;
  logic        underflow;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t q[$];

  fp_adder_normalize_round dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exponent (in_exponent),
    .in_raw      (in_raw),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sign        (sign),
    .exponent    (exponent),
    .significand (significand),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  function automatic res_t mk(input logic s, input logic [7:0] e, input logic [23:0] g,
                              input logic o, input logic u);
    res_t r;
    r.sign = s; r.ex = e; r.sig = g; r.ovf = o; r.unf = u;
    return r;
  endfunction

  // Value-level model: locate the MSB, rescale, round half-to-even on the remainder
  function automatic res_t model(input logic s, input logic [7:0] e, input logic [27:0] r);
    res_t   o;
    int     p;
    int     ex;
    int     sh;
    longint rv, keep, rem, half;
    o = '0;
    o.sign = s;
    if (r == '0) return o;
    p = 0;
    for (int i = 0; i < 28; i++) if (r[i]) p = i;
    ex = int'(e) + p - 26;
    if (ex >= 255) begin o.ex = 8'hFF; o.ovf = 1'b1; return o; end
    if (ex <= 0) begin o.unf = 1'b1; return o; end
    rv = longint'(r);
    sh = p - 23;
    if (sh > 0) begin
      keep = rv >> sh;
      rem  = rv - (keep << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    end else begin
      keep = rv << (-sh);
    end
    if (keep == (longint'(1) << 24)) begin
      keep = longint'(1) << 23;
      ex = ex + 1;
      if (ex >= 255) begin o.ex = 8'hFF; o.ovf = 1'b1; return o; end
    end
    o.ex  = ex[7:0];
    o.sig = keep[23:0];
    return o;
  endfunction

  function automatic logic [35:0] outs();
    return {out_valid, sign, exponent, significand, overflow, underflow};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, score any delivery, queue the expectation on acceptance
  task automatic cycle(input logic v, input logic s, input logic [7:0] e, input logic [27:0] r,
                       input logic ordy, input res_t expv);
    logic acc;
    res_t got;
    in_valid = v; in_sign = s; in_exponent = e; in_raw = r; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      check("deliver_expected", 40'(q.size() != 0), 40'(1));
      if (q.size() != 0) begin
        got = q.pop_front();
        check("sign", 40'(sign), 40'(got.sign));
        check("exponent", 40'(exponent), 40'(got.ex));
        check("significand", 40'(significand), 40'(got.sig));
        check("overflow", 40'(overflow), 40'(got.ovf));
        check("underflow", 40'(underflow), 40'(got.unf));
      end
    end
    acc = in_valid && in_ready;
    @(posedge clock);
    #1;
    if (acc) q.push_back(expv);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) cycle(1'b0, 1'b0, 8'h00, 28'h0, 1'b1, '0);
    check("drain_empty", 40'(q.size()), 40'(0));
  endtask

  initial begin
    logic [35:0] snap;
    snap = '0;
    resetn = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exponent = '0; in_raw = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 40'(out_valid), 40'(0));
    check("rst_outputs", 40'(outs()), 40'(0));
    check("rst_in_ready", 40'(in_ready), 40'(1));
    resetn = 1'b1;

    // Latency: plain normal value appears exactly two edges after acceptance
    cycle(1'b1, 1'b0, 8'h80, 28'h4000000, 1'b1, mk(1'b0, 8'h80, 24'h800000, 1'b0, 1'b0));
    check("lat_edge1_valid", 40'(out_valid), 40'(0));
    cycle(1'b0, 1'b0, 8'h00, 28'h0, 1'b1, '0);
    check("lat_edge2_valid", 40'(out_valid), 40'(1));
    drain();

    // Directed cases, back to back
    cycle(1'b1, 1'b0, 8'h80, 28'h8000000, 1'b1, mk(1'b0, 8'h81, 24'h800000, 1'b0, 1'b0));
    cycle(1'b1, 1'b0, 8'hFE, 28'h8000000, 1'b1, mk(1'b0, 8'hFF, 24'h000000, 1'b1, 1'b0));
    cycle(1'b1, 1'b1, 8'h85, 28'h0100000, 1'b1, mk(1'b1, 8'h7F, 24'h800000, 1'b0, 1'b0));
    cycle(1'b1, 1'b1, 8'h03, 28'h0100000, 1'b1, mk(1'b1, 8'h00, 24'h000000, 1'b0, 1'b1));
    cycle(1'b1, 1'b1, 8'h42, 28'h0000000, 1'b1, mk(1'b1, 8'h00, 24'h000000, 1'b0, 1'b0));
    cycle(1'b1, 1'b0, 8'h80, 28'h4000004, 1'b1, mk(1'b0, 8'h80, 24'h800000, 1'b0, 1'b0));
    cycle(1'b1, 1'b0, 8'h80, 28'h400000C, 1'b1, mk(1'b0, 8'h80, 24'h800002, 1'b0, 1'b0));
    cycle(1'b1, 1'b0, 8'h90, 28'h7FFFFFC, 1'b1, mk(1'b0, 8'h91, 24'h800000, 1'b0, 1'b0));
    cycle(1'b1, 1'b0, 8'hFE, 28'h7FFFFFC, 1'b1, mk(1'b0, 8'hFF, 24'h000000, 1'b1, 1'b0));
    drain();

    // Backpressure: three inputs, then out_ready low for three cycles
    cycle(1'b1, 1'b0, 8'h10, 28'h4000000, 1'b1, mk(1'b0, 8'h10, 24'h800000, 1'b0, 1'b0));
    cycle(1'b1, 1'b0, 8'h20, 28'h2000000, 1'b1, mk(1'b0, 8'h1F, 24'h800000, 1'b0, 1'b0));
    cycle(1'b1, 1'b1, 8'h30, 28'h8000018, 1'b1, mk(1'b1, 8'h31, 24'h800002, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_sign = 1'b0; in_exponent = 8'h55; in_raw = 28'h5555555; out_ready = 1'b0;
      #1;
      check("stall_in_ready", 40'(in_ready), 40'(0));
      check("stall_out_valid", 40'(out_valid), 40'(1));
      if (k == 0) snap = outs();
      else check("stall_hold", 40'(outs()), 40'(snap));
      @(posedge clock);
      #1;
    end
    check("stall_hold_end", 40'(outs()), 40'(snap));
    check("stall_head_exp", 40'(exponent), 40'(8'h1F));
    drain();

    // Reset mid-flight drops both pipeline entries
    cycle(1'b1, 1'b0, 8'h40, 28'h4000000, 1'b1, mk(1'b0, 8'h40, 24'h800000, 1'b0, 1'b0));
    cycle(1'b1, 1'b1, 8'h41, 28'h6000000, 1'b1, mk(1'b1, 8'h41, 24'hC00000, 1'b0, 1'b0));
    in_valid = 1'b0; resetn = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_out_valid", 40'(out_valid), 40'(0));
    check("midrst_outputs", 40'(outs()), 40'(0));
    q.delete();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 8'h00, 28'h0, 1'b1, '0);
      check("midrst_no_output", 40'(out_valid), 40'(0));
    end

    // Randomized traffic with random stalls
    for (int t = 0; t < 400; t++) begin
      logic [27:0] r;
      logic [7:0]  e;
      logic        s;
      logic        v;
      logic        ordy;
      int          kind;
      kind = int'($urandom_range(0, 5));
      case (kind)
        0:       r = 28'($urandom);
        1:       r = 28'($urandom) >> $urandom_range(0, 27);
        2:       r = 28'h0;
        3:       r = {2'b01, 23'($urandom), 3'b100};
        4:       r = {1'b1, 27'($urandom)};
        default: r = 28'($urandom) >> $urandom_range(1, 8);
      endcase
      e = 8'($urandom_range(1, 254));
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom_range(1, 12));
        1:       e = 8'($urandom_range(250, 254));
        default: e = e;
      endcase
      s    = 1'($urandom);
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 8);
      cycle(v, s, e, r, ordy, model(s, e, r));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
